// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart transmitter
// between NREQ byte producers, with guard gap and done watchdog.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 2000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DBIT-1:0]      req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [DBIT-1:0]           din,
  input  logic                      tx_done_tick,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      timeout_err
);

  localparam int GW = $clog2(NREQ);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [GW-1:0]   last_grant;
  logic [WW-1:0]   wd_cnt;
  logic [PW-1:0]   gap_cnt;
  logic [GW-1:0]   win;
  logic            win_vld;
  logic [DBIT-1:0] win_data;
  logic            wd_last;
  logic            gap_last;
  logic            to_hit;
  logic            accept;

  assign wd_last  = (wd_cnt == WW'(TIMEOUT - 1));
  assign gap_last = (gap_cnt == PW'(GAP_LAST));
  assign accept   = (state == IDLE) && win_vld && rst;

  // Search above last_grant first; the second pass is the wrap.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req_valid[i] && GW'(i) > last_grant) begin
        win     = GW'(i);
        win_vld = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req_valid[i]) begin
        win     = GW'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == GW'(i)) begin
        win_data = req_data[i*DBIT +: DBIT];
      end
      req_ready[i] = accept && (win == GW'(i));
    end
  end

  always_comb begin
    state_n = state;
    to_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) state_n = START;
      end
      START: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_tick) begin
          if (GAP_CYC > 0) state_n = GAP;
          else             state_n = IDLE;
        end else if (wd_last) begin
          state_n = IDLE;
          to_hit  = 1'b1;
        end
      end
      GAP: begin
        if (gap_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_start = (state == START);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      din         <= '0;
      grant_id    <= '0;
      last_grant  <= GW'(NREQ - 1);
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
      if (accept) begin
        din        <= win_data;
        grant_id   <= win;
        last_grant <= win;
      end
      if (state == START) begin
        wd_cnt <= '0;
      end else if (state == WAIT_DONE && !tx_done_tick && !wd_last) begin
        wd_cnt <= wd_cnt + WW'(1);
      end
      if (state == GAP && !gap_last) gap_cnt <= gap_cnt + PW'(1);
      else                           gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, gap,
// watchdog and reset behaviour with two parameter sets.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a_valid;
  logic [31:0] a_data;
  logic [3:0]  a_ready;
  logic        a_start;
  logic [7:0]  a_din;
  logic        a_done;
  logic        a_busy;
  logic [1:0]  a_gid;
  logic        a_terr;

  logic [3:0]  b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_ready;
  logic        b_start;
  logic [7:0]  b_din;
  logic        b_done;
  logic        b_busy;
  logic [1:0]  b_gid;
  logic        b_terr;

  int          tests = 0;
  int          fails = 0;
  logic [3:0]  rdy_or;

  uart_tx_arbiter #(
    .NREQ(4), .DBIT(8), .GAP_CYC(16), .TIMEOUT(100)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .tx_start(a_start),
    .din(a_din), .tx_done_tick(a_done),
    .busy(a_busy), .grant_id(a_gid),
    .timeout_err(a_terr)
  );

  uart_tx_arbiter #(
    .NREQ(4), .DBIT(8), .GAP_CYC(0), .TIMEOUT(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .tx_start(b_start),
    .din(b_din), .tx_done_tick(b_done),
    .busy(b_busy), .grant_id(b_gid),
    .timeout_err(b_terr)
  );

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (a_busy && n < 100) begin
      rdy_or |= a_ready;
      n++;
      nc();
      #1;
    end
  endtask

  task automatic run_frame(input int id, input int dly);
    int n;
    #1;
    rdy_or |= a_ready;
    chk("ready", 32'(a_ready), 32'(1) << id);
    nc();
    #1;
    chk("start", 32'(a_start), 1);
    chk("grant", 32'(a_gid), id);
    chk("din", 32'(a_din), (a_data >> (8 * id)) & 32'hFF);
    repeat (dly) nc();
    a_done = 1'b1;
    nc();
    a_done = 1'b0;
    #1;
    wait_idle(n);
    chk("gap", n, 16);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    nc();
    nc();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst     = 1'b0;
    a_valid = '0;
    a_data  = '0;
    a_done  = 1'b0;
    b_valid = '0;
    b_data  = '0;
    b_done  = 1'b0;
    rdy_or  = '0;

    nc();
    nc();
    #1;
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_start", 32'(a_start), 0);
    chk("rst_din", 32'(a_din), 0);
    chk("rst_gid", 32'(a_gid), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_terr", 32'(a_terr), 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    rst = 1'b1;

    // single request, done 5 cycles after start
    a_data  = 32'h0000_0041;
    a_valid = 4'b0001;
    run_frame(0, 5);
    a_valid = '0;
    nc();
    #1;
    chk("t1_idle", 32'(a_busy), 0);

    // all four requesting: strict rotation
    a_data = 32'hD3C2_B1A0;
    do_reset();
    a_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      run_frame(k % 4, 3);
    end

    // sparse request after last_grant=1
    a_valid = 4'b1010;
    rdy_or  = '0;
    run_frame(3, 2);
    run_frame(1, 2);
    a_valid = '0;
    chk("rdy_bits", 32'(rdy_or), 32'h0000_000A);

    // watchdog abort
    a_valid = 4'b0100;
    #1;
    chk("to_ready", 32'(a_ready), 32'h4);
    nc();
    #1;
    chk("to_start", 32'(a_start), 1);
    a_valid = '0;
    n = 0;
    do begin
      nc();
      #1;
      n++;
    end while (!a_terr && n < 300);
    chk("to_lat", n, 101);
    chk("to_idle", 32'(a_busy), 0);
    nc();
    #1;
    chk("to_once", 32'(a_terr), 0);
    a_valid = 4'b0001;
    run_frame(0, 1);

    // reset in the middle of WAIT_DONE
    a_valid = 4'b0010;
    #1;
    chk("r_ready", 32'(a_ready), 32'h2);
    nc();
    #1;
    chk("r_start", 32'(a_start), 1);
    a_valid = '0;
    nc();
    nc();
    rst     = 1'b0;
    a_valid = 4'b1111;
    nc();
    #1;
    chk("r_ready0", 32'(a_ready), 0);
    chk("r_start0", 32'(a_start), 0);
    chk("r_din0", 32'(a_din), 0);
    chk("r_gid0", 32'(a_gid), 0);
    chk("r_busy0", 32'(a_busy), 0);
    chk("r_terr0", 32'(a_terr), 0);
    rst     = 1'b1;
    a_valid = '0;
    a_done  = 1'b1;
    nc();
    a_done = 1'b0;
    #1;
    chk("late_busy", 32'(a_busy), 0);
    chk("late_start", 32'(a_start), 0);
    a_valid = 4'b1111;
    run_frame(0, 2);
    a_valid = '0;

    // no gap: done coincides with watchdog limit
    b_data  = 32'h0000_005A;
    b_valid = 4'b0001;
    #1;
    chk("b_ready", 32'(b_ready), 32'h1);
    nc();
    #1;
    chk("b_start", 32'(b_start), 1);
    chk("b_din", 32'(b_din), 32'h5A);
    repeat (4) nc();
    b_done = 1'b1;
    #1;
    chk("b_busy_w", 32'(b_busy), 1);
    nc();
    b_done = 1'b0;
    #1;
    chk("b_idle", 32'(b_busy), 0);
    chk("b_terr0", 32'(b_terr), 0);
    chk("b_reacc", 32'(b_ready), 32'h1);
    nc();
    #1;
    chk("b_start2", 32'(b_start), 1);
    chk("b_terr1", 32'(b_terr), 0);
    b_valid = '0;
    n = 0;
    do begin
      nc();
      #1;
      n++;
    end while (!b_terr && n < 50);
    chk("b_to_lat", n, 5);
    chk("b_to_idle", 32'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter (tx_start/din/tx_done_tick interface) between NREQ byte-producing requesters.
- Uses round-robin arbitration with a valid/ready accept handshake.
- Sequences each frame: accept, pulse start, wait for done, then an optional inter-frame guard gap.
- A watchdog aborts a frame if the transmitter never signals done.
- Sits between the button/debounce and application logic and the uart instance in the board top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBIT, 8, data bits per frame; must match the uart DBIT.
- GAP_CYC, 16, idle clk cycles inserted after each completed frame (0 = no gap).
- TIMEOUT, 2000000, max clk cycles to wait for tx_done_tick before abort (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester byte available.
- req_data  in  NREQ*DBIT  requester i byte at [i*DBIT +: DBIT].
- req_ready  out  NREQ  one-hot accept; byte i taken when req_valid[i] && req_ready[i].
- tx_start  out  1  one-cycle start pulse to the uart.
- din  out  DBIT  byte to the uart; held stable from tx_start until the frame ends.
- tx_done_tick  in  1  uart transmit-complete pulse.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NREQ)  index of the requester owning the current frame.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst==0 at a clk edge), from any state including mid-frame:
  - state=IDLE, tx_start=0, din=0, grant_id=0, busy=0, timeout_err=0, req_ready=0.
  - last_grant=NREQ-1, so requester 0 has first priority after reset.
  - wd_cnt=0, gap_cnt=0.
  - A frame already started in the uart is abandoned; no done is awaited.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - Winner = first i with req_valid[i], searching (last_grant+1) mod NREQ upward with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits 0.
  - req_ready=0 in every other state.
  - On that edge: din<=winner data, grant_id<=winner, last_grant<=winner, state->START.
  - No valid request: stay in IDLE; din and grant_id hold their previous values.
- START:
  - tx_start=1 for exactly this one cycle (decoded from the state register).
  - wd_cnt<=0; ->WAIT_DONE.
  - Latency: accept at cycle t, tx_start high at t+1.
- WAIT_DONE:
  - tx_done_tick=1: ->GAP if GAP_CYC>0, else ->IDLE.
  - Else if wd_cnt==TIMEOUT-1: timeout_err=1 (registered, high in the next cycle), ->IDLE.
  - Else wd_cnt<=wd_cnt+1.
  - If done and the timeout limit coincide, done wins and timeout_err stays 0.
- GAP:
  - gap_cnt counts 0..GAP_CYC-1; at GAP_CYC-1, ->IDLE.
  - Total idle between tx_done_tick and the next accept is GAP_CYC cycles.
- tx_done_tick outside WAIT_DONE is ignored.
- Requests during START/WAIT_DONE/GAP are not accepted. Requesters must hold req_valid and req_data until accepted; deasserting before acceptance withdraws the request without error.
- After a timeout abort, last_grant still advances, so the aborted requester does not get immediate retry priority.
- Counters are sized from the parameters ($clog2); no wrap occurs within a state.
- busy is decoded from state: 0 only in IDLE.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[7:0]=8'h41:
  - req_ready=0001 in the same cycle; tx_start one cycle later with din=8'h41, grant_id=0.
  - tx_done_tick after 5 cycles -> 16 GAP cycles, then IDLE with busy=0.
- req_valid=4'b1111 held constant, all bytes distinct, tx_done_tick 3 cycles after each tx_start:
  - Grant order 0,1,2,3,0,1.
  - Each din matches that requester's byte; exactly 16 idle cycles between each done and the next accept.
- req_valid=4'b1010 after last_grant=1:
  - Grant order 3 then 1.
  - No req_ready on bits 0/2 at any time.
- tx_done_tick never asserted, TIMEOUT=100:
  - timeout_err pulses exactly once, 101 cycles after tx_start.
  - Returns to IDLE; next request is accepted normally.
- rst=0 during WAIT_DONE:
  - All outputs zero the following cycle.
  - A late tx_done_tick after reset is ignored.
  - The next grant goes to requester 0.
- GAP_CYC=0, done and timeout limit in the same cycle:
  - Direct to IDLE; timeout_err=0.
  - Next accept on the following cycle.
